// File: rtl/tfe_mac_sequencer.sv
// tfe_mac_sequencer: byte-serial command sequencer for the TensorFlowE
// matrix-vector datapath. It holds an NxN weight matrix and an N-vector,
// drives an external 8x8 MAC unit row by row on RUN, and streams each 16-bit
// row result out as two bytes (low byte first) over a valid/ready port.
// Optional build macro TFE_SEQ_RELU_EN: negative row results are replaced by
// zero when captured (ReLU). Cycle timing is the same in both builds.
module tfe_mac_sequencer #(
  parameter int N  = 2,   // matrix dimension / vector length (2..4)
  parameter int DW = 8,   // signed element width
  parameter int AW = 16   // MAC accumulator width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_data,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_clr,
  output logic          mac_en,
  input  logic [AW-1:0] mac_acc,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic          busy,
  output logic          err
);

  localparam int WIW = $clog2(N * N);  // index width into W (and load counter)
  localparam int XIW = $clog2(N);      // index width into X (and row counter)

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_X = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;

  typedef enum logic [2:0] {
    IDLE, LOAD, CLR, MAC, WAIT, OUT_LO, OUT_HI
  } state_t;

  state_t state, state_nxt;

  logic [N*N-1:0][DW-1:0] w_mem;   // row-major weights
  logic [N-1:0][DW-1:0]   x_mem;   // vector
  logic [WIW-1:0]         cnt;     // load index, or column k while in MAC
  logic [XIW-1:0]         row;     // current output row
  logic                   load_w;  // LOAD target: 1 = W, 0 = X
  logic [AW-1:0]          result;  // captured row result

  logic           accept;
  logic           load_last;
  logic           mac_last;
  logic           row_last;
  logic [WIW-1:0] w_idx;

  assign cmd_ready = (state == IDLE) || (state == LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign load_last = load_w ? (cnt == WIW'(N * N - 1)) : (cnt == WIW'(N - 1));
  assign mac_last  = (cnt == WIW'(N - 1));
  assign row_last  = (row == XIW'(N - 1));
  assign w_idx     = WIW'(int'(row) * N + int'(cnt));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and Moore-style outputs from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    res_valid = 1'b0;
    res_data  = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_data)
            OP_LOAD_W, OP_LOAD_X: state_nxt = LOAD;
            OP_RUN:               state_nxt = CLR;
            default:              state_nxt = IDLE;
          endcase
        end
      end
      LOAD: if (cmd_valid && load_last) state_nxt = IDLE;
      CLR: begin
        mac_clr   = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        mac_a  = w_mem[w_idx];
        mac_b  = x_mem[XIW'(cnt)];
        if (mac_last) state_nxt = WAIT;
      end
      WAIT: state_nxt = OUT_LO;
      OUT_LO: begin
        res_valid = 1'b1;
        res_data  = result[7:0];
        if (res_ready) state_nxt = OUT_HI;
      end
      OUT_HI: begin
        res_valid = 1'b1;
        res_data  = result[15:8];
        if (res_ready) state_nxt = row_last ? IDLE : CLR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand store, counters, result capture and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand store is reset on purpose: a RUN before any LOAD
      // must stream zeros, and a reset mid-LOAD must discard partial data.
      w_mem  <= '0;
      x_mem  <= '0;
      cnt    <= '0;
      row    <= '0;
      load_w <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_data)
              OP_NOP:    err <= 1'b0;
              OP_LOAD_W: begin load_w <= 1'b1; cnt <= '0; end
              OP_LOAD_X: begin load_w <= 1'b0; cnt <= '0; end
              OP_RUN:    begin cnt <= '0; row <= '0; end
              default:   err <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          if (accept) begin
            if (load_w) w_mem[cnt]         <= cmd_data;
            else        x_mem[XIW'(cnt)]   <= cmd_data;
            cnt <= cnt + 1'b1;
          end
        end
        MAC: cnt <= mac_last ? '0 : cnt + 1'b1;
        WAIT: begin
`ifdef TFE_SEQ_RELU_EN
          result <= mac_acc[AW-1] ? '0 : mac_acc;
`else
          result <= mac_acc;
`endif
        end
        OUT_HI: if (res_ready) row <= row + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tfe_mac_sequencer.sv
// Self-checking bench for tfe_mac_sequencer. Contains a behavioural model of
// the external MAC (signed, AW-bit wrap, 1-cycle update) and a reference
// model of the expected row results computed directly from W and X.
module tb_tfe_mac_sequencer;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_data = '0;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_clr;
  logic          mac_en;
  logic [AW-1:0] mac_acc;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_data;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] w_ref [N*N];
  logic [7:0] x_ref [N];

  tfe_mac_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // External MAC model.
  logic [AW-1:0] acc_q = '0;
  assign mac_acc = acc_q;
  always @(posedge clk) begin
    if (mac_clr)     acc_q <= '0;
    else if (mac_en) acc_q <= acc_q + AW'(int'($signed(mac_a)) * int'($signed(mac_b)));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected result of one row: dot product, wrapped to 16 bits.
  function automatic logic [15:0] exp_row(input int r);
    int s = 0;
    logic [15:0] v;
    for (int k = 0; k < N; k++)
      s += int'($signed(w_ref[r*N+k])) * int'($signed(x_ref[k]));
    v = s[15:0];
`ifdef TFE_SEQ_RELU_EN
    if (v[15]) v = '0;
`endif
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N*N; i++) w_ref[i] = '0;
    for (int i = 0; i < N; i++)   x_ref[i] = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic load_w(input int gap);
    send_byte(8'h01, 0);
    for (int i = 0; i < N*N; i++) send_byte(w_ref[i], gap);
  endtask

  task automatic load_x(input int gap);
    send_byte(8'h02, 0);
    for (int i = 0; i < N; i++) send_byte(x_ref[i], gap);
  endtask

  // Issue RUN and collect 2*N result bytes.
  // mode 0: always ready; 1: random ready; 2: hold ready low at first OUT_LO.
  task automatic run_check(input int mode, input string tag);
    logic [7:0] exp_b[$];
    logic [15:0] v;
    logic [7:0] held_data;
    int lat = -1, cyc = 0, got_n = 0, en_cnt = 0, clr_cnt = 0;
    bit held = 0;
    bit bp_ok = 1;
    for (int r = 0; r < N; r++) begin
      v = exp_row(r);
      exp_b.push_back(v[7:0]);
      exp_b.push_back(v[15:8]);
    end
    res_ready = 1'b0;
    send_byte(8'h03, 0);
    while (got_n < 2*N && cyc < 400) begin
      @(negedge clk);
      cyc++;
      en_cnt  += int'(mac_en);
      clr_cnt += int'(mac_clr);
      if (res_valid && lat < 0) lat = cyc;
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          res_ready = 1'b1;
          if (res_valid && !held) begin
            held = 1;
            res_ready = 1'b0;
            held_data = res_data;
            for (int i = 0; i < 10; i++) begin
              @(negedge clk);
              cyc++;
              if (res_data !== held_data || mac_en || cmd_ready || !res_valid) bp_ok = 0;
            end
            check({tag, "_hold_data"}, 32'(held_data), 32'(exp_b[0]));
            check({tag, "_hold_stable"}, 32'(bp_ok), 32'd1);
            res_ready = 1'b1;
          end
        end
      endcase
      if (res_valid && res_ready) begin
        check($sformatf("%s_byte%0d", tag, got_n), 32'(res_data), 32'(exp_b[got_n]));
        got_n++;
      end
    end
    check({tag, "_bytes"}, 32'(got_n), 32'(2*N));
    check({tag, "_latency"}, 32'(lat), 32'(N+3));
    check({tag, "_mac_en_cycles"}, 32'(en_cnt), 32'(N*N));
    check({tag, "_mac_clr_cycles"}, 32'(clr_cnt), 32'(N));
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int quiet;
    clear_model();

    // Reset values.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_mac_ctl", {30'd0, mac_en, mac_clr}, 32'd0);
    check("rst_mac_ops", {16'd0, mac_a, mac_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RUN before any LOAD streams zeros.
    run_check(0, "unloaded");

    // Basic run.
    w_ref[0] = 8'd1; w_ref[1] = 8'd2; w_ref[2] = 8'd3; w_ref[3] = 8'd4;
    x_ref[0] = 8'd5; x_ref[1] = 8'd6;
    load_w(0);
    load_x(0);
    run_check(0, "basic");

    // Backpressure held at the first OUT_LO.
    run_check(2, "bp");

    // Gapped X load.
    x_ref[0] = 8'd9; x_ref[1] = 8'd1;
    load_x(0);
    x_ref[0] = 8'd5; x_ref[1] = 8'd6;
    load_x(1);
    run_check(1, "gapped");

    // Negative result.
    w_ref[0] = 8'hFF; w_ref[1] = 8'h00; w_ref[2] = 8'h07; w_ref[3] = 8'hF9;
    x_ref[0] = 8'h05; x_ref[1] = 8'h00;
    load_w(0);
    load_x(0);
    run_check(0, "negative");

    // Opcodes: illegal sets err; LOAD payload treats opcode values as data.
    send_byte(8'h7E, 0);
    @(negedge clk);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_cmd_ready", 32'(cmd_ready), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    w_ref[0] = 8'h03; w_ref[1] = 8'h7E; w_ref[2] = 8'h01; w_ref[3] = 8'h02;
    load_w(0);
    @(negedge clk);
    check("load_keeps_err", 32'(err), 32'd1);
    check("load_opcode_payload_idle", 32'(busy), 32'd0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("nop_clears_err", 32'(err), 32'd0);
    run_check(1, "op_run");

    // Randomised loads and runs.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < N*N; i++) w_ref[i] = 8'($urandom);
        load_w($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < N; i++) x_ref[i] = 8'($urandom);
        load_x($urandom_range(0, 2));
      end
      run_check(1, $sformatf("rand%0d", it));
    end

    // Reset mid-LOAD discards everything, including earlier data.
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    check("midload_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midload_rst_busy", 32'(busy), 32'd0);
    check("midload_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    run_check(0, "after_load_rst");

    // Reset mid-MAC.
    w_ref[0] = 8'd1; w_ref[1] = 8'd2; w_ref[2] = 8'd3; w_ref[3] = 8'd4;
    x_ref[0] = 8'd5; x_ref[1] = 8'd6;
    load_w(0);
    load_x(0);
    send_byte(8'h03, 0);
    @(negedge clk);
    @(negedge clk);
    check("midrun_mac_en_before", 32'(mac_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_mac_en", 32'(mac_en), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_mac_a", 32'(mac_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      quiet += int'(res_valid);
    end
    res_ready = 1'b0;
    check("midrun_no_res_valid", 32'(quiet), 32'd0);
    clear_model();
    run_check(0, "after_run_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tfe_mac_sequencer.md
Name: tfe_mac_sequencer

Overview:
- Command-driven sequencer for the TensorFlowE matrix-vector datapath.
- Receives byte-serial commands from the top-level input bus and holds an NxN weight matrix and an N-vector locally.
- On a RUN command it drives the shared external 8x8 MAC unit row by row, then streams each 16-bit row result out as two bytes with a valid/ready handshake.
- Sits between the tt_um_TensorFlowE pin-mux logic and the MAC unit.

Parameters:
- N, 2, matrix dimension and vector length (2..4).
- DW, 8, element width, signed two's complement.
- AW, 16, accumulator width returned by the MAC.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command byte valid.
- cmd_ready  output  1  sequencer accepts a command byte.
- cmd_data  input  8  command or payload byte.
- mac_a  output  DW  weight operand to MAC.
- mac_b  output  DW  vector operand to MAC.
- mac_clr  output  1  clear MAC accumulator, 1-cycle pulse.
- mac_en  output  1  MAC accumulates mac_a*mac_b this cycle.
- mac_acc  input  AW  MAC accumulator; reflects an mac_en/mac_clr cycle on the following cycle.
- res_valid  output  1  result byte valid.
- res_ready  input  1  downstream accepts result byte.
- res_data  output  8  result byte.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; all W and X registers = 0; counters = 0.
  - mac_a=0, mac_b=0, mac_clr=0, mac_en=0.
  - res_valid=0, res_data=0, busy=0, err=0.
  - cmd_ready=1.
- A byte transfers on a rising edge with valid&ready. A source holds its data stable while valid is high and ready is low.
- Opcodes (first byte in IDLE):
  - 0x00 NOP: clears err.
  - 0x01 LOAD_W: followed by N*N bytes, row-major W[0][0], W[0][1], ...
  - 0x02 LOAD_X: followed by N bytes.
  - 0x03 RUN: no payload.
  - Any other value: sets err=1, stays IDLE.
  - Any valid opcode except NOP leaves err unchanged.
- States: IDLE, LOAD, CLR, MAC, WAIT, OUT_LO, OUT_HI.
- cmd_ready = 1 in IDLE and LOAD, 0 otherwise.
- LOAD:
  - Each accepted byte is written at the index counter; all byte values are treated as payload, including opcode values.
  - Gaps in cmd_valid are allowed.
  - Return to IDLE on the edge accepting the last byte.
- RUN, for each row r = 0..N-1:
  - CLR: 1 cycle, mac_clr=1.
  - MAC: N cycles; cycle k drives mac_en=1, mac_a=W[r][k], mac_b=X[k].
  - WAIT: 1 cycle; capture mac_acc into the result register.
  - OUT_LO: res_valid=1, res_data=result[7:0].
  - OUT_HI: res_valid=1, res_data=result[15:8].
  - Outside MAC, mac_en=0 and mac_a/mac_b hold 0.
- Latency: the RUN-accept edge is followed by CLR; res_valid rises on the (N+3)th cycle after that edge.
- Backpressure: with res_ready low, OUT_LO/OUT_HI hold with res_data stable. The next row starts only after OUT_HI handshakes.
- After the last row's OUT_HI handshake the state returns to IDLE.
- Arithmetic lives in the MAC: signed DW x DW, wrapping AW-bit sum. The sequencer passes result bits unaltered (see optional feature).
- RUN with W or X never loaded uses the reset zeros and streams zeros.
- A new LOAD after RUN overwrites only the indices written.
- rst_n asserted mid-LOAD, mid-MAC or mid-OUT:
  - Immediate return to reset values.
  - Partially loaded data is discarded (zeroed).
  - No further res_valid until a new RUN.

Optional Feature:
- Macro: TFE_SEQ_RELU_EN.
- Defined: at WAIT, a captured result with bit AW-1 set is replaced by 0 before output (ReLU).
- Undefined: raw two's-complement result is streamed.
- Cycle timing is identical in both builds.

Test Plan:
- Bench models the MAC as signed, AW-bit wrap, 1-cycle update.
- Basic run: N=2; LOAD_W 1,2,3,4; LOAD_X 5,6; RUN -> res bytes 0x11,0x00,0x27,0x00; first res_valid 5 cycles after RUN accept; busy low afterwards.
- Negative result: W row0 = 0xFF,0x00 (-1,0); X = 0x05,0x00; RUN -> row0 bytes 0xFB,0xFF. With TFE_SEQ_RELU_EN -> 0x00,0x00.
- Backpressure: hold res_ready=0 for 10 cycles at OUT_LO -> res_data stable at 0x11; no mac_en pulses; cmd_ready=0 throughout.
- Opcodes: 0x7E -> err=1, cmd_ready stays 1; then 0x01 followed by payload byte 0x03 -> payload stored as W[0][0]=3, err still 1; NOP -> err=0.
- Reset mid-run: assert rst_n low during the MAC state -> mac_en=0 and busy=0 immediately. After release, RUN -> 0x00 x4 bytes.
- Gapped load: LOAD_X with cmd_valid toggling every other cycle -> X loaded correctly; run results match the basic run.
